boa_bram_ctrl: RTL and testbench
================================

BOA_BRAM_CTRL -- requirements
Module: boa_bram_ctrl

Interface
REQ-001 SHALL have parameter alen, default 32, bus address width in bits.
REQ-002 SHALL have parameter abits, default 8, RAM word-address width.
REQ-003 SHALL have parameter dbytes, default 4, data bytes per word (power of two).
REQ-004 SHALL have parameter blen, default 8, bits per byte; dbits = dbytes*blen.
REQ-005 SHALL have parameter base_addr, default 0, byte base address, aligned to the region size dbytes<<abits.
REQ-006 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port re  in  1  bus read request.
REQ-009 SHALL have port we  in  dbytes  bus per-byte write enable; nonzero means write request.
REQ-010 SHALL have port addr  in  alen  bus byte address.
REQ-011 SHALL have port wdata  in  dbits  bus write data.
REQ-012 SHALL have port ready  out  1  access complete, one-cycle pulse.
REQ-013 SHALL have port rdata  out  dbits  read data, valid while ready=1.
REQ-014 SHALL have port err  out  1  access fault, valid while ready=1.
REQ-015 SHALL have port ram_we  out  dbytes  RAM per-byte write enable.
REQ-016 SHALL have port ram_addr  out  abits  RAM word address.
REQ-017 SHALL have port ram_wdata  out  dbits  RAM write data.
REQ-018 SHALL have port ram_rdata  in  dbits  RAM registered read data, one-cycle latency.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-020 IDLE: if re=1 or we!=0 at a rising edge, SHALL latch addr, we, wdata and the decode result; go to ACCESS. Otherwise stay in IDLE.
REQ-021 Decode SHALL flag a fault when addr[log2(dbytes)-1:0]!=0, or when addr[alen-1:abits+log2(dbytes)] differs from the same bits of base_addr.
REQ-022 ACCESS, no fault: SHALL drive ram_addr = latched addr[abits+log2(dbytes)-1:log2(dbytes)], ram_wdata = latched wdata, ram_we = latched we; go to RESP unconditionally.
REQ-023 ACCESS, fault: SHALL hold ram_we=0; go to RESP.
REQ-024 ram_we SHALL be 0 in every state other than ACCESS.
REQ-025 RESP: ready=1 combinationally; err = latched fault.
REQ-026 RESP rdata SHALL be ram_rdata for a non-faulting read (we=0), and 0 for writes or faults.
REQ-027 RESP SHALL always go to IDLE. Any request presented at the RESP-exit edge is ignored; the requester holds its request until it samples ready=1.
REQ-028 Latency: request sampled at edge E0 gives ready=1 in the cycle E1..E2; maximum throughput is one access per 3 cycles.
REQ-029 Simultaneous re=1 and we!=0 SHALL be treated as a write; rdata=0.
REQ-030 Request inputs SHALL be ignored while in ACCESS or RESP; only latched values are used.
REQ-031 A partial write (for example we=4'b0010) SHALL modify only the enabled bytes; this is delegated to the RAM through ram_we.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, ready=0, err=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, latches cleared.
REQ-033 Reset during ACCESS SHALL abort the access with no RAM write (ram_we drops asynchronously); no ready is issued for the aborted request.
REQ-034 After rst_n rises, the first request SHALL be accepted at the first rising edge that samples it.

Structure
REQ-035 Package boa_bram_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and a request struct {we, addr, wdata, fault}.
REQ-036 A single combinational sub-module boa_bram_decode SHALL compute the fault flag and the word address from addr, base_addr, abits and dbytes.
REQ-037 The block SHALL connect directly to the single-port block RAM with matching abits, dbytes and blen, in read-before-write mode.

Verification
REQ-038 Reset with rst_n=0, release, idle 5 cycles -> ready=0 and ram_we=0 throughout.
REQ-039 base_addr=0x1000: write we=4'hF, addr=0x1010, wdata=0xDEADBEEF; then read addr=0x1010 -> ready 2 cycles after each accept, err=0, rdata=0xDEADBEEF.
REQ-040 After REQ-039, write we=4'b0010, wdata=0x0000AA00 to 0x1010, then read -> rdata=0xDEADAAEF.
REQ-041 Read addr=0x1012 (misaligned) and addr=0x2000 (out of range) -> ready with err=1, rdata=0, ram_we never nonzero.
REQ-042 re=1 held continuously across 3 back-to-back reads -> exactly one ready pulse per 3 cycles; no request accepted in RESP.
REQ-043 Assert rst_n=0 mid-cycle during ACCESS of a write to 0x1004 -> ram_we drops immediately, no ready; a subsequent read of 0x1004 returns its prior value.

Source files
------------

// File: rtl/boa_bram_pkg.sv
// Shared types for the BOA block-RAM bus controller.
// The request latch is sized for the widest supported configuration.
package boa_bram_pkg;

   localparam int unsigned MAX_ALEN   = 64;
   localparam int unsigned MAX_DBYTES = 16;
   localparam int unsigned MAX_DBITS  = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   // addr holds the decoded RAM word address, not the bus byte address
   typedef struct packed {
      logic [MAX_DBYTES-1:0] we;
      logic [MAX_ALEN-1:0]   addr;
      logic [MAX_DBITS-1:0]  wdata;
      logic                  fault;
   } req_t;

endpackage

// File: rtl/boa_bram_if.sv
// Bus-side and RAM-side signals of the BOA block-RAM controller.
// master: requester plus RAM; slave: the controller.
interface boa_bram_if
   import boa_bram_pkg::*;
#(
   parameter int unsigned alen   = 32,
   parameter int unsigned abits  = 8,
   parameter int unsigned dbytes = 4,
   parameter int unsigned blen   = 8
);
   localparam int unsigned dbits = dbytes * blen;

   logic              re;
   logic [dbytes-1:0] we;
   logic [alen-1:0]   addr;
   logic [dbits-1:0]  wdata;
   logic              ready;
   logic [dbits-1:0]  rdata;
   logic              err;
   logic [dbytes-1:0] ram_we;
   logic [abits-1:0]  ram_addr;
   logic [dbits-1:0]  ram_wdata;
   logic [dbits-1:0]  ram_rdata;

   modport master (
      output re, we, addr, wdata, ram_rdata,
      input  ready, rdata, err, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  re, we, addr, wdata, ram_rdata,
      output ready, rdata, err, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/boa_bram_decode.sv
// Address decode: alignment and region check, word address extraction.
// Purely combinational.
module boa_bram_decode
   import boa_bram_pkg::*;
#(
   parameter int unsigned     alen      = 32,
   parameter int unsigned     abits     = 8,
   parameter int unsigned     dbytes    = 4,
   parameter logic [alen-1:0] base_addr = '0
) (
   input  logic [alen-1:0]  addr,
   output logic             fault,
   output logic [abits-1:0] waddr
);

   localparam int unsigned LSB = $clog2(dbytes);
   localparam int unsigned TOP = abits + LSB;

   logic misalign;
   logic outside;

   if (LSB > 0) begin : g_align
      assign misalign = |addr[LSB-1:0];
   end else begin : g_no_align
      assign misalign = 1'b0;
   end

   // the region fills the whole bus space when TOP reaches alen
   if (TOP < alen) begin : g_range
      assign outside = addr[alen-1:TOP] != base_addr[alen-1:TOP];
   end else begin : g_no_range
      assign outside = 1'b0;
   end

   assign waddr = addr[TOP-1:LSB];
   assign fault = misalign | outside;

endmodule

// File: rtl/boa_bram_ctrl.sv
// Bus-to-block-RAM controller: IDLE -> ACCESS -> RESP, one access per
// three cycles, faulting accesses never reach the RAM.
module boa_bram_ctrl
   import boa_bram_pkg::*;
#(
   parameter int unsigned     alen      = 32,
   parameter int unsigned     abits     = 8,
   parameter int unsigned     dbytes    = 4,
   parameter int unsigned     blen      = 8,
   parameter logic [alen-1:0] base_addr = '0
) (
   input logic      clk,
   input logic      rst_n,
   boa_bram_if.slave bus
);

   localparam int unsigned dbits = dbytes * blen;

   state_e state_q, state_d;
   req_t   req_q, req_d;

   logic             dec_fault;
   logic [abits-1:0] dec_waddr;
   logic             req_any;
   logic             in_access;
   logic             in_resp;
   logic             is_write;
   logic             unused_req;

   boa_bram_decode #(
      .alen      (alen),
      .abits     (abits),
      .dbytes    (dbytes),
      .base_addr (base_addr)
   ) u_decode (
      .addr  (bus.addr),
      .fault (dec_fault),
      .waddr (dec_waddr)
   );

   assign req_any = bus.re | (|bus.we);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      unique case (state_q)
         IDLE: begin
            if (req_any) begin
               state_d     = ACCESS;
               req_d.we    = MAX_DBYTES'(bus.we);
               req_d.addr  = MAX_ALEN'(dec_waddr);
               req_d.wdata = MAX_DBITS'(bus.wdata);
               req_d.fault = dec_fault;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   assign in_access = state_q == ACCESS;
   assign in_resp   = state_q == RESP;
   // any enabled byte makes it a write, even with re also set
   assign is_write  = |req_q.we[dbytes-1:0];

   always_comb begin
      bus.ready  = in_resp;
      bus.err    = in_resp & req_q.fault;
      bus.rdata  = '0;
      bus.ram_we = '0;
      if (in_resp && !req_q.fault && !is_write)
         bus.rdata = bus.ram_rdata;
      if (in_access && !req_q.fault)
         bus.ram_we = req_q.we[dbytes-1:0];
   end

   assign bus.ram_addr  = req_q.addr[abits-1:0];
   assign bus.ram_wdata = req_q.wdata[dbits-1:0];

   assign unused_req = ^req_q;

endmodule

// File: tb/tb_boa_bram_ctrl.sv
// Directed bench for boa_bram_ctrl with a read-before-write RAM model.
// base_addr = 0x1000, 256 x 32-bit words.
module tb_boa_bram_ctrl;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   logic [31:0] mem [256];

   boa_bram_if #(
      .alen   (32),
      .abits  (8),
      .dbytes (4),
      .blen   (8)
   ) bus ();

   boa_bram_ctrl #(
      .alen      (32),
      .abits     (8),
      .dbytes    (4),
      .blen      (8),
      .base_addr (32'h0000_1000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
         if (bus.ram_we[b])
            mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
   end

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic txn(input string       tag,
                      input logic        r,
                      input logic [3:0]  w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  e_we,
                      input logic [7:0]  e_waddr,
                      input logic        e_err,
                      input logic [31:0] e_rd);
      int n;
      n = 0;
      @(negedge clk);
      bus.re    = r;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({tag, "_acc_rdy"}, 32'(bus.ready), 32'd0);
            chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'(e_we));
            if (e_we != 4'h0)
               chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(e_waddr));
         end
      end while (!bus.ready && n < 10);
      chk({tag, "_lat"}, 32'(n), 32'd2);
      chk({tag, "_err"}, 32'(bus.err), 32'(e_err));
      chk({tag, "_rdata"}, bus.rdata, e_rd);
      bus.re = 1'b0;
      bus.we = 4'h0;
   endtask

   initial begin
      int pulses;
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.re    = 1'b0;
      bus.we    = 4'h0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      rst_n     = 1'b0;

      #1;
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_wdata", bus.ram_wdata, 32'd0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(bus.ready), 32'd0);
         chk("idle_ram_we", 32'(bus.ram_we), 32'd0);
      end

      txn("wr_full", 1'b0, 4'hF, 32'h1010, 32'hDEADBEEF,
          4'hF, 8'h04, 1'b0, 32'h0);
      txn("rd_full", 1'b1, 4'h0, 32'h1010, 32'h0,
          4'h0, 8'h04, 1'b0, 32'hDEADBEEF);
      txn("wr_part", 1'b0, 4'b0010, 32'h1010, 32'h0000AA00,
          4'b0010, 8'h04, 1'b0, 32'h0);
      txn("rd_part", 1'b1, 4'h0, 32'h1010, 32'h0,
          4'h0, 8'h04, 1'b0, 32'hDEADAAEF);
      txn("rd_misal", 1'b1, 4'h0, 32'h1012, 32'h0,
          4'h0, 8'h00, 1'b1, 32'h0);
      txn("rd_range", 1'b1, 4'h0, 32'h2000, 32'h0,
          4'h0, 8'h00, 1'b1, 32'h0);
      txn("wr_range", 1'b0, 4'hF, 32'h2010, 32'h55555555,
          4'h0, 8'h00, 1'b1, 32'h0);
      txn("rd_after_flt", 1'b1, 4'h0, 32'h1010, 32'h0,
          4'h0, 8'h04, 1'b0, 32'hDEADAAEF);
      txn("wr_rdwe", 1'b1, 4'hF, 32'h1020, 32'h12345678,
          4'hF, 8'h08, 1'b0, 32'h0);
      txn("rd_rdwe", 1'b1, 4'h0, 32'h1020, 32'h0,
          4'h0, 8'h08, 1'b0, 32'h12345678);

      @(negedge clk);
      bus.re   = 1'b1;
      bus.addr = 32'h1010;
      pulses   = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("b2b_ready", 32'(bus.ready), (i % 3 == 2) ? 32'd1 : 32'd0);
         if (bus.ready) begin
            pulses++;
            chk("b2b_rdata", bus.rdata, 32'hDEADAAEF);
         end
      end
      bus.re = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd3);

      txn("wr_pre", 1'b0, 4'hF, 32'h1004, 32'h11223344,
          4'hF, 8'h01, 1'b0, 32'h0);

      @(negedge clk);
      bus.we    = 4'hF;
      bus.addr  = 32'h1004;
      bus.wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("abort_we_pre", 32'(bus.ram_we), 32'hF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_we", 32'(bus.ram_we), 32'd0);
      chk("abort_ready", 32'(bus.ready), 32'd0);
      bus.we = 4'h0;
      @(negedge clk);
      chk("abort_hold_rdy", 32'(bus.ready), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_rdy", 32'(bus.ready), 32'd0);
      end

      txn("rd_abort", 1'b1, 4'h0, 32'h1004, 32'h0,
          4'h0, 8'h01, 1'b0, 32'h11223344);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
